// File: rtl/fb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_pkg : frame-buffer geometry defaults and arbiter state encoding
// Revision 1.0
// ----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_DATA_W = 36;
    localparam int FB_ADDR_W = 12;
    localparam int FB_DEPTH  = 3200;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_HOST = 2'd2
    } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_arbiter_if : display, host, swap and RAM signals of the frame-buffer arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
interface fb_arbiter_if
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W
);

    logic              i_disp_req;
    logic [ADDR_W-1:0] i_disp_addr;
    logic              o_disp_ack;
    logic              o_disp_valid;
    logic [DATA_W-1:0] o_disp_data;

    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;
    logic              o_wr_err;

    logic              i_swap_req;
    logic              i_frame_end;
    logic              o_swap_pending;
    logic              o_swap_done;
    logic              o_front_bank;

    logic [ADDR_W:0]   o_mem_addr;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport master (
        output i_disp_req, i_disp_addr, i_wr_req, i_wr_addr, i_wr_data,
               i_swap_req, i_frame_end, i_mem_rdata,
        input  o_disp_ack, o_disp_valid, o_disp_data, o_wr_ack, o_wr_err,
               o_swap_pending, o_swap_done, o_front_bank,
               o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport slave (
        input  i_disp_req, i_disp_addr, i_wr_req, i_wr_addr, i_wr_data,
               i_swap_req, i_frame_end, i_mem_rdata,
        output o_disp_ack, o_disp_valid, o_disp_data, o_wr_ack, o_wr_err,
               o_swap_pending, o_swap_done, o_front_bank,
               o_mem_addr, o_mem_we, o_mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_arbiter : display-priority arbiter and front/back bank owner for the frame-buffer RAM
// Revision 1.0
// ----------------------------------------------------------------------------
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    fb_arbiter_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    fb_state_t         state;
    logic              front_bank;
    logic              swap_pending;
    logic              swap_done;
    logic              swap_fire;
    logic              front_nxt;
    logic              wr_legal;
    logic              disp_ack;
    logic              disp_valid;
    logic              wr_ack;
    logic              wr_err;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] data_hold;

    // Commands issued in the cycle a swap lands must already see the new bank.
    assign swap_fire = bus.i_frame_end && (swap_pending || bus.i_swap_req);
    assign front_nxt = swap_fire ? ~front_bank : front_bank;
    assign wr_legal  = ({1'b0, bus.i_wr_addr} < DEPTH_EXT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            front_bank   <= front_nxt;
            swap_done    <= swap_fire;
            swap_pending <= !swap_fire && (swap_pending || bus.i_swap_req);
        end
    end

    // A requester granted in this slot is excluded from the next one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            disp_ack   <= 1'b0;
            disp_valid <= 1'b0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            data_hold  <= '0;
        end else begin
            disp_ack   <= 1'b0;
            wr_ack     <= 1'b0;
            mem_we     <= 1'b0;
            disp_valid <= disp_ack;
            if (disp_valid) begin
                data_hold <= bus.i_mem_rdata;
            end
            if (bus.i_disp_req && state != S_DISP) begin
                state    <= S_DISP;
                disp_ack <= 1'b1;
                mem_addr <= {front_nxt, bus.i_disp_addr};
            end else if (bus.i_wr_req && state != S_HOST) begin
                state     <= S_HOST;
                wr_ack    <= 1'b1;
                mem_we    <= wr_legal;
                mem_addr  <= {~front_nxt, bus.i_wr_addr};
                mem_wdata <= bus.i_wr_data;
                if (!wr_legal) begin
                    wr_err <= 1'b1;
                end
            end else begin
                state <= S_IDLE;
            end
        end
    end

    // RAM data arrives one cycle after the read command, aligned with disp_valid.
    assign bus.o_disp_data    = disp_valid ? bus.i_mem_rdata : data_hold;
    assign bus.o_disp_ack     = disp_ack;
    assign bus.o_disp_valid   = disp_valid;
    assign bus.o_wr_ack       = wr_ack;
    assign bus.o_wr_err       = wr_err;
    assign bus.o_swap_pending = swap_pending;
    assign bus.o_swap_done    = swap_done;
    assign bus.o_front_bank   = front_bank;
    assign bus.o_mem_addr     = mem_addr;
    assign bus.o_mem_we       = mem_we;
    assign bus.o_mem_wdata    = mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fb_arbiter : randomized scoreboard bench for fb_arbiter with a RAM model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_fb_arbiter;

    localparam int DW    = 36;
    localparam int AW    = 12;
    localparam int DEPTH = 3200;
    localparam int WORDS = 1 << (AW + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return {i * 32'h9E3779B1, 4'(i)};
    endfunction

    // Single-port RAM, one cycle read latency.
    logic [DW-1:0] ram [WORDS];
    bit            ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (bus.o_mem_we) begin
            ram[bus.o_mem_addr] <= bus.o_mem_wdata;
        end
        bus.i_mem_rdata <= ram[bus.o_mem_addr];
    end

    typedef struct {
        int            cyc;
        logic [AW:0]   addr;
        logic          flag;
        logic [DW-1:0] data;
    } ev_t;

    ev_t dack_q[$];
    ev_t wack_q[$];
    ev_t rd_q[$];
    ev_t swp_q[$];

    logic [DW-1:0] ref_mem [WORDS];
    int   cyc        = 0;
    int   vectors    = 0;
    int   errors     = 0;
    int   last_grant = 0;   // 0 none, 1 display, 2 host
    logic m_front    = 1'b0;
    logic m_pend     = 1'b0;
    logic m_err      = 1'b0;
    logic m_in_rst   = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: applies the arbitration, bank and swap rules to the inputs seen at a posedge.
    task automatic model_step();
        int   g;
        logic fire;
        logic legal;
        cyc++;
        if (!rst_n) begin
            m_front = 1'b0; m_pend = 1'b0; m_err = 1'b0;
            last_grant = 0; m_in_rst = 1'b1;
            dack_q.delete(); wack_q.delete(); rd_q.delete(); swp_q.delete();
            return;
        end
        m_in_rst = 1'b0;
        fire = bus.i_frame_end && (m_pend || bus.i_swap_req);
        if (fire) begin
            m_front = ~m_front;
            m_pend  = 1'b0;
            swp_q.push_back('{cyc, '0, 1'b1, '0});
        end else if (bus.i_swap_req) begin
            m_pend = 1'b1;
        end
        g = 0;
        if (bus.i_disp_req && last_grant != 1)    g = 1;
        else if (bus.i_wr_req && last_grant != 2) g = 2;
        last_grant = g;
        if (g == 1) begin
            dack_q.push_back('{cyc, {m_front, bus.i_disp_addr}, 1'b0, '0});
            rd_q.push_back('{cyc + 1, '0, 1'b1, ref_mem[{m_front, bus.i_disp_addr}]});
        end else if (g == 2) begin
            legal = (int'(bus.i_wr_addr) < DEPTH);
            wack_q.push_back('{cyc, {~m_front, bus.i_wr_addr}, legal, bus.i_wr_data});
            if (legal) ref_mem[{~m_front, bus.i_wr_addr}] = bus.i_wr_data;
            else       m_err = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_disp_req  = 1'b0;
        bus.i_disp_addr = '0;
        bus.i_wr_req    = 1'b0;
        bus.i_wr_addr   = '0;
        bus.i_wr_data   = '0;
        bus.i_swap_req  = 1'b0;
        bus.i_frame_end = 1'b0;
    endtask

    // Requests are held until the model grants them, then re-rolled.
    task automatic drive_random(input int p_disp, input int p_wr, input int p_bad, input bit swaps);
        bus.i_swap_req  = swaps && ($urandom_range(0, 15) == 0);
        bus.i_frame_end = swaps && ($urandom_range(0, 19) == 0);
        if (!bus.i_disp_req || last_grant == 1) begin
            bus.i_disp_req  = ($urandom_range(0, 99) < p_disp);
            bus.i_disp_addr = AW'($urandom_range(0, DEPTH - 1));
        end
        if (!bus.i_wr_req || last_grant == 2) begin
            bus.i_wr_req  = ($urandom_range(0, 99) < p_wr);
            bus.i_wr_addr = ($urandom_range(0, 99) < p_bad) ? AW'($urandom_range(DEPTH, 4095))
                                                             : AW'($urandom_range(0, DEPTH - 1));
            bus.i_wr_data = DW'({$urandom(), $urandom()});
        end
    endtask

    task automatic wait_grant(input int g);
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_grant == g) break;
        end
    endtask

    // Monitor: pops expected events when the DUT should present them.
    logic [DW-1:0] last_data = '0;
    always @(negedge clk) begin
        ev_t e;
        if (cyc > 0) begin
            if (m_in_rst) last_data = '0;
            if (dack_q.size() > 0 && dack_q[0].cyc == cyc) begin
                e = dack_q.pop_front();
                chk("disp_ack", 64'(bus.o_disp_ack), 64'd1);
                chk("disp_mem_addr", 64'(bus.o_mem_addr), 64'(e.addr));
                chk("disp_mem_we", 64'(bus.o_mem_we), 64'd0);
            end else begin
                chk("disp_ack_idle", 64'(bus.o_disp_ack), 64'd0);
            end
            if (wack_q.size() > 0 && wack_q[0].cyc == cyc) begin
                e = wack_q.pop_front();
                chk("wr_ack", 64'(bus.o_wr_ack), 64'd1);
                chk("wr_mem_addr", 64'(bus.o_mem_addr), 64'(e.addr));
                chk("wr_mem_we", 64'(bus.o_mem_we), 64'(e.flag));
                if (e.flag) chk("wr_mem_wdata", 64'(bus.o_mem_wdata), 64'(e.data));
            end else begin
                chk("wr_ack_idle", 64'(bus.o_wr_ack), 64'd0);
                chk("mem_we_idle", 64'(bus.o_mem_we), 64'd0);
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                e = rd_q.pop_front();
                chk("disp_valid", 64'(bus.o_disp_valid), 64'd1);
                chk("disp_data", 64'(bus.o_disp_data), 64'(e.data));
                last_data = e.data;
            end else begin
                chk("disp_valid_idle", 64'(bus.o_disp_valid), 64'd0);
                chk("disp_data_hold", 64'(bus.o_disp_data), 64'(last_data));
            end
            if (swp_q.size() > 0 && swp_q[0].cyc == cyc) begin
                e = swp_q.pop_front();
                chk("swap_done", 64'(bus.o_swap_done), 64'(e.flag));
            end else begin
                chk("swap_done_idle", 64'(bus.o_swap_done), 64'd0);
            end
            chk("front_bank", 64'(bus.o_front_bank), 64'(m_front));
            chk("swap_pending", 64'(bus.o_swap_pending), 64'(m_pend));
            chk("wr_err", 64'(bus.o_wr_err), 64'(m_err));
            if (m_in_rst) chk("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
        end
    end

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Display only, then display and host both saturating.
        repeat (40) begin step(); drive_random(100, 0, 0, 1'b0); end
        repeat (40) begin step(); drive_random(100, 100, 0, 1'b0); end

        // Out-of-range write, then a legal one; error must stay sticky.
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = AW'(DEPTH);
        bus.i_wr_data = {DW{1'b1}};
        wait_grant(2);
        bus.i_wr_req  = 1'b0;
        repeat (3) step();
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = AW'(17);
        bus.i_wr_data = DW'(36'h123456789);
        wait_grant(2);
        bus.i_wr_req  = 1'b0;
        repeat (3) step();

        // Swap request 40 cycles before frame end, under traffic.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) begin step(); drive_random(100, 100, 0, 1'b0); end
        bus.i_swap_req = 1'b1;
        repeat (40) begin step(); drive_random(100, 100, 0, 1'b0); end
        bus.i_frame_end = 1'b1;
        repeat (4) begin step(); drive_random(100, 100, 0, 1'b0); end
        // Front is now 1: swap request and frame end together.
        bus.i_swap_req  = 1'b1;
        bus.i_frame_end = 1'b1;
        repeat (4) begin step(); drive_random(100, 100, 0, 1'b0); end

        // Long randomized run with swaps and occasional illegal writes.
        repeat (2000) begin step(); drive_random(60, 50, 10, 1'b1); end

        // Reset in the cycle after a display ack drops the in-flight read.
        clear_inputs();
        step();
        bus.i_disp_req  = 1'b1;
        bus.i_disp_addr = AW'(42);
        wait_grant(1);
        rst_n = 1'b0;
        bus.i_disp_req = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();

        clear_inputs();
        repeat (4) step();
        chk("drain_queues", 64'(dack_q.size() + wack_q.size() + rd_q.size() + swp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
